// File: rtl/fpga_bootloader_if.sv
// FTDI FIFO and FPGA slave-serial pins seen by the bootloader bridge.
interface fpga_bootloader_if;
  logic        ftdi_clk;
  logic [15:0] ftdi_data;
  logic        ftdi_rxf_n;
  logic        ftdi_rd_n;
  logic        ftdi_gpio_0;
  logic        ftdi_gpio_1;
  logic        fpga_program_b;
  logic        fpga_init_b;
  logic        fpga_done;
  logic        fpga_bl_clk;
  logic        fpga_bl_data;
  logic        dbg;

  modport slave (
    input  ftdi_clk, ftdi_data, ftdi_rxf_n, ftdi_gpio_0, ftdi_gpio_1,
    input  fpga_program_b, fpga_init_b, fpga_done,
    output ftdi_rd_n, fpga_bl_clk, fpga_bl_data, dbg
  );

  modport master (
    output ftdi_clk, ftdi_data, ftdi_rxf_n, ftdi_gpio_0, ftdi_gpio_1,
    output fpga_program_b, fpga_init_b, fpga_done,
    input  ftdi_rd_n, fpga_bl_clk, fpga_bl_data, dbg
  );
endinterface

// File: rtl/fpga_bootloader.sv
// Bridges the FTDI 16-bit receive FIFO to a Xilinx slave-serial port: each word is
// shifted MSB first on CCLK/DIN, followed by EXTRA_CCLK trailing clocks once DONE rises.
module fpga_bootloader #(
  parameter int EXTRA_CCLK = 8
) (
  input  logic             clk,
  input  logic             rst,
  fpga_bootloader_if.slave bif
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_REQ, S_SHIFT, S_TRAIL, S_DONE
  } state_t;

  localparam int CW = (EXTRA_CCLK > 16) ? $clog2(EXTRA_CCLK) : 4;
  localparam logic [CW-1:0] BIT_LOAD   = CW'(15);
  localparam logic [CW-1:0] TRAIL_LOAD = CW'(EXTRA_CCLK - 1);

  // Sync bit order: {ftdi_clk, rxf_n, gpio_0, gpio_1, program_b, init_b, done}
  logic [6:0] meta_d, meta_q, sync_d, sync_q;
  logic       fclk_prev_d, fclk_prev_q;

  state_t        state_d, state_q;
  logic [15:0]   shreg_d, shreg_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          phase_d, phase_q;
  logic          bl_clk_d, bl_clk_q;
  logic          bl_data_d, bl_data_q;
  logic          rd_n_d, rd_n_q;
  logic          start_trail;

  logic fclk_s, rxf_s, gpio0_s, gpio1_s, prog_s, init_s, done_s, fclk_rise;
  assign fclk_s    = sync_q[6];
  assign rxf_s     = sync_q[5];
  assign gpio0_s   = sync_q[4];
  assign gpio1_s   = sync_q[3];
  assign prog_s    = sync_q[2];
  assign init_s    = sync_q[1];
  assign done_s    = sync_q[0];
  assign fclk_rise = fclk_s & ~fclk_prev_q;

  always_comb begin
    meta_d      = {bif.ftdi_clk, bif.ftdi_rxf_n, bif.ftdi_gpio_0, bif.ftdi_gpio_1,
                   bif.fpga_program_b, bif.fpga_init_b, bif.fpga_done};
    sync_d      = meta_q;
    fclk_prev_d = fclk_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      fclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      bl_clk_q    <= 1'b0;
      bl_data_q   <= 1'b0;
      rd_n_q      <= 1'b1;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bl_clk_q    <= bl_clk_d;
      bl_data_q   <= bl_data_d;
      rd_n_q      <= rd_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bl_clk_d    = bl_clk_q;
    bl_data_d   = bl_data_q;
    rd_n_d      = 1'b1;
    start_trail = 1'b0;
    case (state_q)
      S_IDLE: if (gpio0_s && prog_s) state_d = S_WAIT_INIT;
      S_WAIT_INIT: if (init_s && !done_s) state_d = S_REQ;
      S_REQ: begin
        if (!init_s) begin
          state_d = S_IDLE;
        end else if (done_s) begin
          start_trail = 1'b1;
        end else if (fclk_rise && !rxf_s && !rd_n_q) begin
          state_d   = S_SHIFT;
          shreg_d   = bif.ftdi_data;
          cnt_d     = BIT_LOAD;
          phase_d   = 1'b0;
          bl_clk_d  = 1'b0;
          bl_data_d = bif.ftdi_data[15];
        end else begin
          rd_n_d = rxf_s;
        end
      end
      S_SHIFT: begin
        if (!init_s) begin
          state_d = S_IDLE;
        end else if (!phase_q) begin
          phase_d  = 1'b1;
          bl_clk_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          bl_clk_d = 1'b0;
          if (cnt_q == '0) begin
            if (done_s) start_trail = 1'b1;
            else        state_d = S_REQ;
          end else begin
            cnt_d     = cnt_q - 1'b1;
            shreg_d   = {shreg_q[14:0], 1'b0};
            bl_data_d = shreg_q[14];
          end
        end
      end
      S_TRAIL: begin
        if (!phase_q) begin
          phase_d  = 1'b1;
          bl_clk_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          bl_clk_d = 1'b0;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        bl_clk_d = 1'b0;
        if (!gpio0_s || !prog_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_trail) begin
      state_d   = S_TRAIL;
      cnt_d     = TRAIL_LOAD;
      phase_d   = 1'b0;
      bl_clk_d  = 1'b0;
      bl_data_d = 1'b1;
    end
    if (!prog_s || gpio1_s) state_d = S_IDLE;
    // Every path into IDLE drops the partial word and parks the pins.
    if (state_d == S_IDLE) begin
      shreg_d   = '0;
      cnt_d     = '0;
      phase_d   = 1'b0;
      bl_clk_d  = 1'b0;
      bl_data_d = 1'b0;
      rd_n_d    = 1'b1;
    end
  end

  assign bif.ftdi_rd_n    = rd_n_q;
  assign bif.fpga_bl_clk  = bl_clk_q;
  assign bif.fpga_bl_data = bl_data_q;
  assign bif.dbg          = (state_q == S_REQ) || (state_q == S_SHIFT);
endmodule

// File: tb/tb_fpga_bootloader.sv
// Directed bench for fpga_bootloader: FIFO model on the FTDI side, CCLK/DIN capture on the FPGA side.
module tb_fpga_bootloader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fclk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  fpga_bootloader_if bif();
  fpga_bootloader #(.EXTRA_CCLK(8)) dut (.clk(clk), .rst(rst), .bif(bif));

  always #10 clk = ~clk;
  always #100 bif.ftdi_clk = fclk_en ? ~bif.ftdi_clk : 1'b0;

  // FIFO model: a word is consumed when the bridge releases rd_n after latching it.
  logic [15:0] fifo_mem [0:2047];
  logic [10:0] wr_ptr = '0;
  logic [10:0] rd_ptr = '0;
  assign bif.ftdi_rxf_n = (wr_ptr == rd_ptr);
  assign bif.ftdi_data  = fifo_mem[rd_ptr];
  always @(posedge bif.ftdi_rd_n) if (!rst && wr_ptr != rd_ptr) rd_ptr = rd_ptr + 1'b1;

  logic bit_q[$];
  time  t_q[$];
  int   rd_falls = 0;
  int   setup_err = 0;
  logic data_neg;
  always @(negedge clk) data_neg = bif.fpga_bl_data;
  always @(posedge bif.fpga_bl_clk) begin
    if (bif.fpga_bl_data !== data_neg) setup_err++;
    bit_q.push_back(bif.fpga_bl_data);
    t_q.push_back($time);
  end
  always @(negedge bif.ftdi_rd_n) if (!rst) rd_falls++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic wait_bits(input string tag, input int target, input int budget);
    int k = 0;
    while (bit_q.size() < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 32'(bit_q.size() >= target), 32'd1);
  endtask

  function automatic logic [15:0] word_at(input int idx);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], bit_q[idx + i]};
    return w;
  endfunction

  initial begin
    int b, b2, f;
    bif.ftdi_gpio_0    = 1'b0;
    bif.ftdi_gpio_1    = 1'b0;
    bif.fpga_program_b = 1'b0;
    bif.fpga_init_b    = 1'b0;
    bif.fpga_done      = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_bl_clk",  32'(bif.fpga_bl_clk),  32'd0);
    chk("rst_bl_data", 32'(bif.fpga_bl_data), 32'd0);
    chk("rst_rd_n",    32'(bif.ftdi_rd_n),    32'd1);
    chk("rst_dbg",     32'(bif.dbg),          32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_rd_n",     32'(bif.ftdi_rd_n), 32'd1);
    chk("idle_rd_falls", rd_falls,           32'd0);

    // single word
    b = bit_q.size(); f = rd_falls;
    push(16'hA55A);
    bif.fpga_program_b = 1'b1;
    bif.fpga_init_b    = 1'b1;
    bif.ftdi_gpio_0    = 1'b1;
    fclk_en            = 1'b1;
    wait_bits("single_done", b + 16, 500);
    chk("single_word",   32'(word_at(b)), 32'hA55A);
    chk("single_span",   32'(t_q[b + 15] - t_q[b]), 32'd600);
    chk("single_rd_low", rd_falls - f, 32'd1);

    // empty FIFO: parked in REQ
    b = bit_q.size();
    repeat (100) @(negedge clk);
    chk("empty_no_clk",   bit_q.size() - b,      32'd0);
    chk("empty_rd_n",     32'(bif.ftdi_rd_n),   32'd1);
    chk("empty_rd_falls", rd_falls - f,          32'd1);
    chk("empty_dbg",      32'(bif.dbg),         32'd1);

    // burst of 1024 incrementing words
    b = bit_q.size(); f = rd_falls;
    for (int i = 0; i < 1024; i++) push(16'h3C00 + i[15:0]);
    wait_bits("burst_done", b + 16 * 1024, 1024 * 48);
    for (int i = 0; i < 1024; i++)
      chk("burst_word", 32'(word_at(b + 16 * i)), 32'(16'h3C00 + i[15:0]));
    chk("burst_rd_low", rd_falls - f, 32'd1024);

    // DONE mid-stream: finish current word, then 8 trailing ones
    b = bit_q.size(); f = rd_falls;
    push(16'hC3C3); push(16'h5A0F); push(16'h0001);
    wait_bits("dn_mid", b + 21, 300);
    @(negedge clk); bif.fpga_done = 1'b1;
    wait_bits("dn_trail", b + 40, 300);
    repeat (100) @(negedge clk);
    chk("dn_total",      bit_q.size() - b,            32'd40);
    chk("dn_word1",      32'(word_at(b)),             32'hC3C3);
    chk("dn_word2",      32'(word_at(b + 16)),        32'h5A0F);
    chk("dn_trail_ones", 32'(word_at(b + 24)),        32'h0FFF);
    chk("dn_rd_low",     rd_falls - f,                32'd2);
    chk("dn_rd_n",       32'(bif.ftdi_rd_n),          32'd1);
    chk("dn_bl_clk",     32'(bif.fpga_bl_clk),        32'd0);
    chk("dn_dbg",        32'(bif.dbg),                32'd0);

    wr_ptr = rd_ptr;
    bif.fpga_done   = 1'b0;
    bif.ftdi_gpio_0 = 1'b0;
    repeat (6) @(negedge clk);
    bif.ftdi_gpio_0 = 1'b1;
    repeat (6) @(negedge clk);

    // PROGRAM_B pulled low mid-word
    b = bit_q.size();
    push(16'h1234);
    wait_bits("pb_mid", b + 6, 300);
    @(negedge clk); bif.fpga_program_b = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("pb_bl_clk",  32'(bif.fpga_bl_clk),  32'd0);
    chk("pb_bl_data", 32'(bif.fpga_bl_data), 32'd0);
    chk("pb_dbg",     32'(bif.dbg),          32'd0);
    b2 = bit_q.size(); f = rd_falls;
    repeat (50) @(negedge clk);
    chk("pb_no_clk",   bit_q.size() - b2,  32'd0);
    chk("pb_rd_falls", rd_falls - f,       32'd0);
    bif.fpga_program_b = 1'b1;
    repeat (6) @(negedge clk);

    // INIT_B low during SHIFT (CRC error)
    b = bit_q.size();
    push(16'hBEEF);
    wait_bits("crc_mid", b + 3, 300);
    @(negedge clk); bif.fpga_init_b = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("crc_dbg",    32'(bif.dbg),         32'd0);
    chk("crc_bl_clk", 32'(bif.fpga_bl_clk), 32'd0);
    b2 = bit_q.size();
    repeat (30) @(negedge clk);
    chk("crc_no_clk", bit_q.size() - b2, 32'd0);
    bif.fpga_init_b = 1'b1;
    repeat (6) @(negedge clk);

    // async reset while CCLK is high
    b = bit_q.size();
    push(16'hFFFF);
    wait_bits("ar_mid", b + 4, 300);
    chk("ar_pre_clk",  32'(bif.fpga_bl_clk),  32'd1);
    chk("ar_pre_data", 32'(bif.fpga_bl_data), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_bl_clk",  32'(bif.fpga_bl_clk),  32'd0);
    chk("ar_bl_data", 32'(bif.fpga_bl_data), 32'd0);
    chk("ar_rd_n",    32'(bif.ftdi_rd_n),    32'd1);
    chk("ar_dbg",     32'(bif.dbg),          32'd0);
    #5 rst = 1'b0;

    chk("data_setup", setup_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
